ascon_perm_ctrl: RTL
====================

Name: ascon_perm_ctrl

Overview:
Sequencer and initiator for the Ascon permutation core. It accepts a 320-bit state and a round count over a valid/ready input handshake, and drives the core's load_val, rounds_enable and round_ctr controls. It consumes the core's rounds_done flag and returns the permuted state over a valid/ready output handshake. It sits between the AEAD/hash datapath and the permutation core, and supports p^a (12 rounds) and p^b (6 or 8 rounds).

Parameters:
NUM_ROUNDS, 12, max rounds; must equal the core's NUM_ROUNDS; counter terminal value
CTR_W, 4, width of round_ctr

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  request carries a state to permute
in_ready  output  1  controller can accept a request
in_nrounds  input  4  rounds to apply (1..12)
in_S_0 .. in_S_4  input  64 each  initial state words
out_valid  output  1  permuted state available
out_ready  input  1  consumer takes the result
out_S_0 .. out_S_4  output  64 each  permuted state words
perm_load_val  output  1  to core load_val
perm_S_0_load_val .. perm_S_4_load_val  output  64 each  to core load values
perm_rounds_enable  output  1  to core rounds_enable
perm_round_ctr  output  CTR_W  to core round_ctr
perm_rounds_done  input  1  from core rounds_done (round_ctr == NUM_ROUNDS)
perm_S_0_reg .. perm_S_4_reg  input  64 each  core state registers

Behaviour:
- One clock domain. Reset is asynchronous and active-low, on port rst_n.
- Reset values: FSM=IDLE; round_ctr=NUM_ROUNDS, so the core is parked with rounds_done=1.
- Reset output values: in_ready=1, out_valid=0, perm_load_val=0, perm_rounds_enable=0.
- FSM states are IDLE, RUN and DONE, encoded in 2 bits.
- IDLE: in_ready=1.
  - perm_S_x_load_val = in_S_x, combinational pass-through at all times.
  - perm_load_val = in_valid & in_ready, combinational, so the core loads on the accept edge.
  - On the accept edge: round_ctr <= NUM_ROUNDS - n_eff; FSM <= RUN.
- n_eff: equals in_nrounds if 1 <= in_nrounds <= NUM_ROUNDS, otherwise NUM_ROUNDS (0 and 13..15 clamp to 12).
- RUN: perm_rounds_enable=1, in_ready=0.
  - Each edge with round_ctr < NUM_ROUNDS: round_ctr <= round_ctr + 1. The core applies one round on the same edge.
  - When perm_rounds_done=1: round_ctr holds and FSM <= DONE.
- DONE: perm_rounds_enable=0, out_valid=1, out_S_x = perm_S_x_reg (stable).
  - On out_valid & out_ready: FSM <= IDLE.
- Latency: counting from the accept edge E0, edges E1..En apply the rounds. perm_rounds_done rises after En, the FSM enters DONE at E(n+1), and out_valid is high in the cycle after E(n+1).
- No back-to-back acceptance from DONE: in_ready=0 in DONE. One IDLE cycle separates requests.
- out_valid, once high, holds until the handshake completes, independent of out_ready.
- in_nrounds is sampled only on the accept edge. Later changes are ignored.
- round_ctr never exceeds NUM_ROUNDS and never wraps. Increment is saturating.
- rst_n low mid-RUN or mid-DONE: the FSM returns to IDLE and round_ctr to NUM_ROUNDS immediately. Any in-flight result is discarded.

Test Plan:
- Reset: after rst_n deassert, check in_ready=1, out_valid=0, perm_round_ctr=12, perm_rounds_enable=0.
- p^a: in_nrounds=12, Ascon-128 IV state (S_0=80400c0600000000, key/nonce zero) accepted at E0.
  - perm_round_ctr steps 0..12.
  - out_valid first high after E13.
  - out_S matches the golden software permutation.
- p^b: in_nrounds=6, then 8.
  - Check start counters 6 and 4.
  - Check out_valid after 7 and 9 edges.
  - Check constants 0x96..0x4b applied (out_S matches golden).
- Clamp: in_nrounds=0 and in_nrounds=15 behave exactly as 12 rounds.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid and out_S are stable.
  - in_ready=0 even with in_valid=1.
  - After the handshake, one IDLE cycle follows before the next accept.
- Abort: assert rst_n low at round 3 of 12.
  - Outputs return to reset values asynchronously.
  - A new 6-round request then completes correctly.

Source files
------------

// File: rtl/ascon_perm_ctrl.sv
// Sequencer for the Ascon permutation core: loads a state, steps the round counter
// until the core reports completion, then holds the permuted state for the consumer.
module ascon_perm_ctrl #(
    parameter int NUM_ROUNDS = 12,
    parameter int CTR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_nrounds,
    input  logic [63:0]      in_S_0,
    input  logic [63:0]      in_S_1,
    input  logic [63:0]      in_S_2,
    input  logic [63:0]      in_S_3,
    input  logic [63:0]      in_S_4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_S_0,
    output logic [63:0]      out_S_1,
    output logic [63:0]      out_S_2,
    output logic [63:0]      out_S_3,
    output logic [63:0]      out_S_4,
    output logic             perm_load_val,
    output logic [63:0]      perm_S_0_load_val,
    output logic [63:0]      perm_S_1_load_val,
    output logic [63:0]      perm_S_2_load_val,
    output logic [63:0]      perm_S_3_load_val,
    output logic [63:0]      perm_S_4_load_val,
    output logic             perm_rounds_enable,
    output logic [CTR_W-1:0] perm_round_ctr,
    input  logic             perm_rounds_done,
    input  logic [63:0]      perm_S_0_reg,
    input  logic [63:0]      perm_S_1_reg,
    input  logic [63:0]      perm_S_2_reg,
    input  logic [63:0]      perm_S_3_reg,
    input  logic [63:0]      perm_S_4_reg,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CTR_W-1:0] NR_CTR = CTR_W'(NUM_ROUNDS);
    localparam logic [3:0]       NR_IN  = 4'(NUM_ROUNDS);

    state_t           state;
    logic [CTR_W-1:0] n_eff;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never drops before that edge and payload is stable while it waits.

    // Out-of-range round counts run the full permutation.
    always_comb begin
        n_eff = NR_CTR;
        if (in_nrounds != 4'd0 && in_nrounds <= NR_IN) begin
            n_eff = CTR_W'(in_nrounds);
        end
    end

    assign perm_load_val     = in_valid & in_ready;
    assign perm_S_0_load_val = in_S_0;
    assign perm_S_1_load_val = in_S_1;
    assign perm_S_2_load_val = in_S_2;
    assign perm_S_3_load_val = in_S_3;
    assign perm_S_4_load_val = in_S_4;

    assign out_S_0 = perm_S_0_reg;
    assign out_S_1 = perm_S_1_reg;
    assign out_S_2 = perm_S_2_reg;
    assign out_S_3 = perm_S_3_reg;
    assign out_S_4 = perm_S_4_reg;

    assign dbg_state = state;

    // Parked counter keeps the core reporting rounds_done while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            perm_round_ctr     <= NR_CTR;
            in_ready           <= 1'b1;
            out_valid          <= 1'b0;
            perm_rounds_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state              <= RUN;
                        perm_round_ctr     <= NR_CTR - n_eff;
                        in_ready           <= 1'b0;
                        perm_rounds_enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (perm_rounds_done) begin
                        state              <= DONE;
                        perm_rounds_enable <= 1'b0;
                        out_valid          <= 1'b1;
                    end else if (perm_round_ctr < NR_CTR) begin
                        perm_round_ctr <= perm_round_ctr + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state              <= IDLE;
                    perm_round_ctr     <= NR_CTR;
                    in_ready           <= 1'b1;
                    out_valid          <= 1'b0;
                    perm_rounds_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
